frame_packer: RTL and testbench

Serial-to-parallel framer feeding the 8-lane FFT input stage. Accepts one 8-bit sample per handshake, packs samples into lanes o1..o8 in arrival order, and closes a frame after 8 samples or on a sample flagged last. Unfilled lanes are driven to zero, and the valid-sample count is presented on `cnt`. The 8-lane frame and count are exactly what the lane-masking filter downstream consumes.

---
 rtl/frame_packer.sv | 154 +++++++++++++++
 tb/tb_frame_packer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_packer.sv
// frame_packer: serial-to-parallel framer for the 8-lane FFT input stage.
//
// Collects one WIDTH-bit sample per s_valid/s_ready handshake into lanes
// o1..o8 in arrival order. A frame closes after the 8th sample or on a
// sample flagged s_last. The closed frame then moves into the output
// register set. Lanes that were not filled read as zero, and cnt gives
// the number of valid lanes.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready     sample input stream (AXI-style, sender holds data)
//   o1..o8, cnt        frame lanes and valid-lane count (1..8)
//   out_valid/out_ready output frame handshake

// One lane: a collect register and an output register. The collect
// register clears on transfer, so lanes not written in a short frame
// always read as zero.
module frame_packer_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             xfer,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] lane
);
    logic [WIDTH-1:0] col;

    // wr and xfer never coincide: accepts only happen while not pending,
    // and transfers only happen while pending.
    always_ff @(posedge clk) begin
        if (!rst_n)     col <= '0;
        else if (xfer)  col <= '0;
        else if (wr)    col <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     lane <= '0;
        else if (xfer)  lane <= col;
    end
endmodule

module frame_packer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic [WIDTH-1:0] o8,
    output logic [3:0]       cnt,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int NUM_LANES = 8;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                            state, state_nxt;
    logic   [2:0]                      idx;
    logic   [3:0]                      cnt_lat;
    logic                              pending;
    logic                              accept;
    logic                              close;
    logic                              xfer;
    logic   [NUM_LANES-1:0]            lane_wr;
    logic   [NUM_LANES-1:0][WIDTH-1:0] lanes;

    assign pending = (state == ST_PENDING);
    // s_ready depends only on registered state, never on s_valid/s_last.
    assign s_ready = !pending;
    assign accept  = s_valid && s_ready;
    assign close   = accept && ((idx == 3'd7) || s_last);
    // A closed frame moves out when the output slot is empty or is
    // being drained this same cycle.
    assign xfer    = pending && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_COLLECT: if (close) state_nxt = ST_PENDING;
            ST_PENDING: if (xfer)  state_nxt = ST_COLLECT;
            default:               state_nxt = ST_COLLECT;
        endcase
    end

    // Fill index. On close it stays where it is (the count is latched
    // separately), and the transfer rewinds it to lane 0.
    always_ff @(posedge clk) begin
        if (!rst_n)                idx <= '0;
        else if (xfer)             idx <= '0;
        else if (accept && !close) idx <= idx + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     cnt_lat <= '0;
        else if (close) cnt_lat <= 4'(idx) + 4'd1;
    end

    // The output count follows the lanes. When the slot drains it holds
    // its last value.
    always_ff @(posedge clk) begin
        if (!rst_n)     cnt <= '0;
        else if (xfer)  cnt <= cnt_lat;
    end

    // Transfer takes priority over drain: a new frame keeps out_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n)          out_valid <= 1'b0;
        else if (xfer)       out_valid <= 1'b1;
        else if (out_ready)  out_valid <= 1'b0;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_wr[i] = accept && (idx == 3'(i));

        frame_packer_lane #(.WIDTH(WIDTH)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .wr   (lane_wr[i]),
            .xfer (xfer),
            .din  (s_data),
            .lane (lanes[i])
        );
    end

    assign o1 = lanes[0];
    assign o2 = lanes[1];
    assign o3 = lanes[2];
    assign o4 = lanes[3];
    assign o5 = lanes[4];
    assign o6 = lanes[5];
    assign o7 = lanes[6];
    assign o8 = lanes[7];
endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: directed and randomised checks for frame_packer.
// A driver task tracks the frame that is being collected. Every closed
// frame is pushed onto an expected queue. A negedge monitor pops one
// entry per output handshake and compares lanes and cnt against it.
module tb_frame_packer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8;
    logic [3:0] cnt;
    logic       out_valid;
    logic       out_ready;

    int nchk  = 0;
    int nfail = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] lanes;
        logic [3:0]  cnt;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] cur[8];
    int         cur_n = 0;
    int         nframes_seen = 0;
    logic       rnd_on = 1'b0;

    frame_packer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7), .o8(o8),
        .cnt(cnt), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] out_lanes();
        return {o1, o2, o3, o4, o5, o6, o7, o8};
    endfunction

    // The model pads zeros by itself from the sample count.
    task automatic model_push(input logic [7:0] d, input logic last);
        frame_t f;
        cur[cur_n] = d;
        cur_n++;
        if (last || cur_n == 8) begin
            f.lanes = '0;
            for (int k = 0; k < 8; k++)
                if (k < cur_n) f.lanes[63-8*k -: 8] = cur[k];
            f.cnt = 4'(cur_n);
            exp_q.push_back(f);
            cur_n = 0;
        end
    endtask

    // Present one sample and hold it until it is accepted. This task is
    // called at posedge+1, so s_ready is already stable for the next edge.
    task automatic send(input logic [7:0] d, input logic last);
        int w;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        w = 0;
        while (!s_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!s_ready) chk("send_ready_timeout", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        model_push(d, last);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard and backpressure-stability monitor. Both sample on the
    // falling edge, away from the active edge.
    logic        stall_prev = 1'b0;
    logic [63:0] hold_lanes;
    logic [3:0]  hold_cnt;
    always @(negedge clk) begin
        if (rst_n && stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_lanes", out_lanes(), hold_lanes);
            chk("hold_cnt", 64'(cnt), 64'(hold_cnt));
        end
        if (rst_n && out_valid && out_ready) begin
            nframes_seen++;
            if (exp_q.size() == 0) begin
                chk("sb_extra_frame", 64'd1, 64'd0);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                chk("sb_lanes", out_lanes(), f.lanes);
                chk("sb_cnt", 64'(cnt), 64'(f.cnt));
            end
        end
        stall_prev = rst_n && out_valid && !out_ready;
        hold_lanes = out_lanes();
        hold_cnt   = cnt;
    end

    initial begin
        logic [63:0] f1;
        rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lanes", out_lanes(), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        chk("rst_ready", 64'(s_ready), 64'd1);

        // Full frame, back to back.
        for (int k = 1; k <= 8; k++) send(8'(k * 8'h11), 1'b0);
        chk("full_ready_low", 64'(s_ready), 64'd0);
        chk("full_valid_t1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("full_valid_t2", 64'(out_valid), 64'd1);
        chk("full_ready_back", 64'(s_ready), 64'd1);
        chk("full_lanes", out_lanes(), 64'h1122334455667788);
        chk("full_cnt", 64'(cnt), 64'd8);
        wait_drain();

        // Short frame, then a full frame. Lanes 4..8 must not keep residue.
        send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b1);
        @(posedge clk); #1;
        chk("short_lanes", out_lanes(), 64'hA1A2A30000000000);
        chk("short_cnt", 64'(cnt), 64'd3);
        for (int k = 0; k < 8; k++) send(8'hB0 + 8'(k), 1'b0);
        wait_drain();

        // Backpressure: two full frames while downstream stalls.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(8'h01 + 8'(k), 1'b0);
        f1 = 64'h0102030405060708;
        for (int k = 0; k < 8; k++) send(8'h09 + 8'(k), 1'b0);
        chk("bp_ready_low", 64'(s_ready), 64'd0);
        chk("bp_first_held", out_lanes(), f1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("bp_stall_ready", 64'(s_ready), 64'd0);
            chk("bp_stall_lanes", out_lanes(), f1);
        end
        out_ready = 1'b1;
        wait_drain();

        // Edge counts.
        send(8'h5A, 1'b1);
        @(posedge clk); #1;
        chk("one_lanes", out_lanes(), 64'h5A00000000000000);
        chk("one_cnt", 64'(cnt), 64'd1);
        for (int k = 0; k < 8; k++) send(8'hC0 + 8'(k), k == 7);
        send(8'hD1, 1'b1);
        wait_drain();

        // Reset in the middle of a frame.
        for (int k = 0; k < 5; k++) send(8'hE0 + 8'(k), 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        cur_n = 0;
        exp_q.delete();
        chk("mrst_lanes", out_lanes(), 64'd0);
        chk("mrst_cnt", 64'(cnt), 64'd0);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ready", 64'(s_ready), 64'd1);
        rst_n = 1'b1;
        send(8'hF1, 1'b0); send(8'hF2, 1'b0); send(8'hF3, 1'b1);
        @(posedge clk); #1;
        chk("mrst_new_lanes", out_lanes(), 64'hF1F2F30000000000);
        chk("mrst_new_cnt", 64'(cnt), 64'd3);
        wait_drain();

        // Random traffic and backpressure.
        nframes_seen = 0;
        rnd_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(8'($urandom), $urandom_range(4) == 0);
                end
                if (cur_n != 0) send(8'h77, 1'b1);
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        chk("rnd_frames_seen_nonzero", 64'(nframes_seen > 40), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
